axi_lite_arbiter: RTL and testbench
===================================

Name: axi_lite_arbiter

Overview:
- Shares one AXI-Lite slave port between NUM_MASTERS AXI-Lite masters (e.g. BFM/CPU plus a DMA engine) in front of axi_lite_slave.
- Round-robin arbitration, one outstanding transaction (read or write) at a time.
- Registered grant. Transparent combinational forwarding of the granted master's channels while the transaction is in progress.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- NUM_MASTERS, 2, number of upstream masters (2..8)
- TIMEOUT_CYCLES, 256, response timeout; used only with AXI_ARB_TIMEOUT_EN

Ports:
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  reset; synchronous, active-high
- s_awaddr / s_awvalid / s_awready  in/in/out  NUM_MASTERS*ADDR_WIDTH / NUM_MASTERS / NUM_MASTERS  upstream AW channels, master i at slice i
- s_wdata / s_wstrb / s_wvalid / s_wready  in/in/in/out  N*DATA_WIDTH / N*STRB_WIDTH / N / N  upstream W channels
- s_bresp / s_bvalid / s_bready  out/out/in  N*2 / N / N  upstream B channels
- s_araddr / s_arvalid / s_arready  in/in/out  N*ADDR_WIDTH / N / N  upstream AR channels
- s_rdata / s_rresp / s_rvalid / s_rready  out/out/out/in  N*DATA_WIDTH / N*2 / N / N  upstream R channels
- m_awaddr, m_awvalid, m_awready, m_wdata, m_wstrb, m_wvalid, m_wready, m_bresp, m_bvalid, m_bready, m_araddr, m_arvalid, m_arready, m_rdata, m_rresp, m_rvalid, m_rready  mirrored dir  single-width  downstream AXI-Lite master port to the slave
- grant  out  $clog2(NUM_MASTERS) (min 1)  index of current/last granted master
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all m_*valid, m_bready, m_rready, s_*ready, s_bvalid, s_rvalid = 0; busy = 0; grant = NUM_MASTERS-1, so master 0 has top priority after reset; FSM = IDLE.
- Reset mid-transaction: abandon the transaction at the next edge; downstream valids drop; no response is returned upstream.
- Request of master i: s_awvalid[i] | s_arvalid[i].
- FSM states: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA.
- IDLE:
  - Search masters starting at grant+1 (mod NUM_MASTERS) and pick the first requester.
  - Register grant and go to WR_ADDR if its awvalid is set (write wins over read for the same master), else RD_ADDR.
  - No requester: stay in IDLE.
  - Latency: grant takes effect 1 cycle after the request is sampled.
- WR_ADDR:
  - Forward AW and W of the granted master independently; m_awvalid = s_awvalid[g] & ~aw_done, likewise for W.
  - Ready is routed back to master g only. Set aw_done / w_done on the respective handshake; AW and W may complete in either order or the same cycle.
  - When both are done (including a same-cycle handshake), go to WR_RESP.
- WR_RESP: forward m_bvalid/m_bresp to master g and s_bready[g] to m_bready. On the handshake, go to IDLE.
- RD_ADDR: forward AR of master g. On the handshake, go to RD_DATA.
- RD_DATA: forward R to master g. On the handshake, go to IDLE.
- Non-granted masters: all their ready/valid outputs stay 0. Their data/resp outputs may carry any value.
- Back-to-back: returning to IDLE costs 1 idle cycle between transactions; grant advances so a continuously requesting master cannot starve others.
- Data/address are never modified; widths pass through unchanged.

Optional Feature:
- AXI_ARB_TIMEOUT_EN defined:
  - A counter starts on entry to WR_RESP or RD_DATA.
  - If the downstream response is not seen within TIMEOUT_CYCLES cycles, the arbiter drives SLVERR (2'b10) to master g, with rdata = 0 for reads. It holds that response until the upstream handshake, then returns to IDLE.
  - A late downstream response arriving after this is accepted and discarded via m_bready/m_rready = 1 in IDLE until it is seen.
- AXI_ARB_TIMEOUT_EN undefined: no counter; the arbiter waits indefinitely; the TIMEOUT_CYCLES parameter is unused.

Test Plan:
- Single master: m0 writes 0xABCDEF to 0x10, then reads 0x10 -> m0 sees bresp 00 and rdata 0x00ABCDEF; m1 readies stay 0; grant = 0.
- Simultaneous: m0 and m1 both request writes (0x10←0x1, 0x14←0x2) in the same cycle after reset -> m0 served first, then m1; both bresp 00; readback gives 0x1 / 0x2.
- Starvation check: m0 issues continuous reads while m1 requests one read of 0x14 -> m1 is granted no later than the second transaction after its request.
- Channel skew: m1 asserts W 3 cycles before AW -> exactly one downstream write, bvalid only to m1, FSM passes through WR_RESP once.
- Reset mid-read: assert areset while in RD_DATA -> next edge all valids/readies 0, busy 0, grant = NUM_MASTERS-1; a new m0 write afterwards completes normally.
- With AXI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave model withholds rvalid -> m0 receives rresp 10 and rdata 0 at cycle 16 after entering RD_DATA; arbiter returns to IDLE.

Source files
------------

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: round-robin N:1 AXI-Lite arbiter, one outstanding transaction; define AXI_ARB_TIMEOUT_EN for a response timeout
module axi_lite_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int NUM_MASTERS    = 2,
   parameter int TIMEOUT_CYCLES = 256,
   localparam int GW            = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                              aclk,
   input  logic                              areset,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_awaddr,
   input  logic [NUM_MASTERS-1:0]            s_awvalid,
   output logic [NUM_MASTERS-1:0]            s_awready,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_wdata,
   input  logic [NUM_MASTERS*STRB_WIDTH-1:0] s_wstrb,
   input  logic [NUM_MASTERS-1:0]            s_wvalid,
   output logic [NUM_MASTERS-1:0]            s_wready,
   output logic [NUM_MASTERS*2-1:0]          s_bresp,
   output logic [NUM_MASTERS-1:0]            s_bvalid,
   input  logic [NUM_MASTERS-1:0]            s_bready,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_araddr,
   input  logic [NUM_MASTERS-1:0]            s_arvalid,
   output logic [NUM_MASTERS-1:0]            s_arready,
   output logic [NUM_MASTERS*DATA_WIDTH-1:0] s_rdata,
   output logic [NUM_MASTERS*2-1:0]          s_rresp,
   output logic [NUM_MASTERS-1:0]            s_rvalid,
   input  logic [NUM_MASTERS-1:0]            s_rready,
   output logic [ADDR_WIDTH-1:0]             m_awaddr,
   output logic                              m_awvalid,
   input  logic                              m_awready,
   output logic [DATA_WIDTH-1:0]             m_wdata,
   output logic [STRB_WIDTH-1:0]             m_wstrb,
   output logic                              m_wvalid,
   input  logic                              m_wready,
   input  logic [1:0]                        m_bresp,
   input  logic                              m_bvalid,
   output logic                              m_bready,
   output logic [ADDR_WIDTH-1:0]             m_araddr,
   output logic                              m_arvalid,
   input  logic                              m_arready,
   input  logic [DATA_WIDTH-1:0]             m_rdata,
   input  logic [1:0]                        m_rresp,
   input  logic                              m_rvalid,
   output logic                              m_rready,
   output logic [GW-1:0]                     grant,
   output logic                              busy
);
   typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA} state_t;
   state_t                  r_state, w_state_n;
   logic [GW-1:0]           r_grant, w_grant_n, w_pick, w_idx;
   logic                    r_aw_done, r_w_done, w_aw_done_n, w_w_done_n;
   logic [NUM_MASTERS-1:0]  w_req;
   logic                    w_to, w_drain_b, w_drain_r;
   logic [1:0]              w_bresp, w_rresp;
   logic [DATA_WIDTH-1:0]   w_rdata;

   if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("axi_lite_arbiter: unsupported parameter values");
   end

   assign w_req    = s_awvalid | s_arvalid;
   assign grant    = r_grant;
   assign busy     = r_state != IDLE;
   assign m_awaddr = s_awaddr[r_grant*ADDR_WIDTH +: ADDR_WIDTH];
   assign m_wdata  = s_wdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
   assign m_wstrb  = s_wstrb[r_grant*STRB_WIDTH +: STRB_WIDTH];
   assign m_araddr = s_araddr[r_grant*ADDR_WIDTH +: ADDR_WIDTH];
   assign w_bresp  = w_to ? 2'b10 : m_bresp;
   assign w_rresp  = w_to ? 2'b10 : m_rresp;
   assign w_rdata  = w_to ? '0 : m_rdata;
   assign s_bresp  = {NUM_MASTERS{w_bresp}};
   assign s_rresp  = {NUM_MASTERS{w_rresp}};
   assign s_rdata  = {NUM_MASTERS{w_rdata}};

   // Round-robin pick: scan from farthest to nearest after the last grant so the nearest requester wins
   always_comb begin
      w_pick = r_grant;
      w_idx  = r_grant;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         w_idx = GW'((int'(r_grant) + k) % NUM_MASTERS);
         if (w_req[w_idx]) w_pick = w_idx;
      end
   end

   // Next-state and channel routing; only the granted master sees ready/valid
   always_comb begin
      w_state_n   = r_state;
      w_grant_n   = r_grant;
      w_aw_done_n = r_aw_done;
      w_w_done_n  = r_w_done;
      m_awvalid   = 1'b0;
      m_wvalid    = 1'b0;
      m_arvalid   = 1'b0;
      m_bready    = 1'b0;
      m_rready    = 1'b0;
      s_awready   = '0;
      s_wready    = '0;
      s_arready   = '0;
      s_bvalid    = '0;
      s_rvalid    = '0;
      case (r_state)
         IDLE: begin
            m_bready = w_drain_b;
            m_rready = w_drain_r;
            if (|w_req) begin
               w_grant_n   = w_pick;
               w_state_n   = s_awvalid[w_pick] ? WR_ADDR : RD_ADDR;
               w_aw_done_n = 1'b0;
               w_w_done_n  = 1'b0;
            end
         end
         WR_ADDR: begin
            m_awvalid          = s_awvalid[r_grant] & ~r_aw_done;
            m_wvalid           = s_wvalid[r_grant] & ~r_w_done;
            s_awready[r_grant] = m_awready & ~r_aw_done;
            s_wready[r_grant]  = m_wready & ~r_w_done;
            w_aw_done_n        = r_aw_done | (m_awvalid & m_awready);
            w_w_done_n         = r_w_done | (m_wvalid & m_wready);
            if (w_aw_done_n & w_w_done_n) w_state_n = WR_RESP;
         end
         WR_RESP: begin
            s_bvalid[r_grant] = w_to | m_bvalid;
            m_bready          = w_to ? w_drain_b : s_bready[r_grant];
            if ((w_to | m_bvalid) & s_bready[r_grant]) w_state_n = IDLE;
         end
         RD_ADDR: begin
            m_arvalid          = s_arvalid[r_grant];
            s_arready[r_grant] = m_arready;
            if (s_arvalid[r_grant] & m_arready) w_state_n = RD_DATA;
         end
         RD_DATA: begin
            s_rvalid[r_grant] = w_to | m_rvalid;
            m_rready          = w_to ? w_drain_r : s_rready[r_grant];
            if ((w_to | m_rvalid) & s_rready[r_grant]) w_state_n = IDLE;
         end
         default: w_state_n = IDLE;
      endcase
   end

   // State, grant and write-channel completion registers
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state   <= IDLE;
         r_grant   <= GW'(NUM_MASTERS - 1);
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_grant   <= w_grant_n;
         r_aw_done <= w_aw_done_n;
         r_w_done  <= w_w_done_n;
      end
   end

`ifdef AXI_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_cnt;
   logic          r_to, r_drain_b, r_drain_r;
   logic          w_wait, w_seen;
   assign w_wait    = (r_state == WR_RESP) | (r_state == RD_DATA);
   assign w_seen    = (r_state == WR_RESP) ? m_bvalid : m_rvalid;
   assign w_to      = r_to;
   assign w_drain_b = r_drain_b;
   assign w_drain_r = r_drain_r;

   // Response watchdog; on expiry remember which channel still owes a late response to swallow
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_cnt     <= '0;
         r_to      <= 1'b0;
         r_drain_b <= 1'b0;
         r_drain_r <= 1'b0;
      end else begin
         if (m_bvalid & m_bready) r_drain_b <= 1'b0;
         if (m_rvalid & m_rready) r_drain_r <= 1'b0;
         if (!w_wait) begin
            r_cnt <= '0;
            r_to  <= 1'b0;
         end else if (!r_to && !w_seen) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               r_to <= 1'b1;
               if (r_state == WR_RESP) r_drain_b <= 1'b1;
               else r_drain_r <= 1'b1;
            end
         end
      end
   end
`else
   assign w_to      = 1'b0;
   assign w_drain_b = 1'b0;
   assign w_drain_r = 1'b0;
`endif
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: directed scoreboard bench for axi_lite_arbiter with a behavioural AXI-Lite slave
module tb_axi_lite_arbiter;
   localparam int N = 2, AW = 32, DW = 32, SW = 4, BOUND = 300;

   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic [N*AW-1:0] s_awaddr = '0, s_araddr = '0;
   logic [N*DW-1:0] s_wdata = '0;
   logic [N*SW-1:0] s_wstrb = '0;
   logic [N-1:0]    s_awvalid = '0, s_wvalid = '0, s_arvalid = '0, s_bready = '1, s_rready = '1;
   logic [N-1:0]    s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
   logic [N*2-1:0]  s_bresp, s_rresp;
   logic [N*DW-1:0] s_rdata;
   logic [AW-1:0]   m_awaddr, m_araddr;
   logic [DW-1:0]   m_wdata, m_rdata;
   logic [SW-1:0]   m_wstrb;
   logic            m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
   logic            m_awready, m_wready, m_arready, m_rvalid;
   logic            m_bvalid = 1'b0;
   logic [1:0]      m_bresp, m_rresp;
   logic [0:0]      grant;
   logic            busy;

   axi_lite_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .NUM_MASTERS(N), .TIMEOUT_CYCLES(16)) dut (
      .aclk(clk), .areset(rst),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .grant(grant), .busy(busy)
   );

   // Behavioural slave: word memory, independent AW/W capture, optional withheld read data
   logic [31:0]   mem [64];
   logic          sl_aw = 1'b0, sl_w = 1'b0, sl_rp = 1'b0, hold_r = 1'b0;
   logic [AW-1:0] sl_addr = '0;
   logic [DW-1:0] sl_data = '0;
   logic [SW-1:0] sl_strb = '0;
   int            n_wr = 0, n_bdn = 0;
   initial for (int i = 0; i < 64; i++) mem[i] = '0;
   initial m_rdata = '0;
   assign m_awready = !sl_aw && !m_bvalid;
   assign m_wready  = !sl_w && !m_bvalid;
   assign m_arready = !sl_rp;
   assign m_rvalid  = sl_rp && !hold_r;
   assign m_bresp   = 2'b00;
   assign m_rresp   = 2'b00;

   always @(posedge clk) begin
      if (rst) begin
         sl_aw    <= 1'b0;
         sl_w     <= 1'b0;
         sl_rp    <= 1'b0;
         m_bvalid <= 1'b0;
      end else begin
         if (m_awvalid && m_awready) begin sl_aw <= 1'b1; sl_addr <= m_awaddr; end
         if (m_wvalid && m_wready) begin sl_w <= 1'b1; sl_data <= m_wdata; sl_strb <= m_wstrb; end
         if (sl_aw && sl_w) begin
            for (int b = 0; b < SW; b++) if (sl_strb[b]) mem[sl_addr[7:2]][b*8 +: 8] <= sl_data[b*8 +: 8];
            sl_aw    <= 1'b0;
            sl_w     <= 1'b0;
            m_bvalid <= 1'b1;
            n_wr     <= n_wr + 1;
         end
         if (m_bvalid && m_bready) begin m_bvalid <= 1'b0; n_bdn <= n_bdn + 1; end
         if (m_arvalid && m_arready) begin sl_rp <= 1'b1; m_rdata <= mem[m_araddr[7:2]]; end
         if (m_rvalid && m_rready) sl_rp <= 1'b0;
      end
   end

   int          checks = 0, errors = 0;
   logic [1:0]  b_q [N][$];
   logic [33:0] r_q [N][$];
   int          b_ord[$], r_ord[$];
   int          phase = 0, m1_act = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Upstream monitor: pop the scoreboard on every response handshake and check exclusivity
   always @(negedge clk) begin
      logic [N-1:0] act;
      if (!rst) begin
         act = s_awready | s_wready | s_arready | s_bvalid | s_rvalid;
         if (act != '0) chk("one_master_active", 64'($countones(act) <= 1), 1);
         if (phase == 1 && act[1]) m1_act++;
         for (int i = 0; i < N; i++) begin
            if (s_bvalid[i] && s_bready[i]) begin
               b_ord.push_back(i);
               chk($sformatf("b_expected_m%0d", i), 64'(b_q[i].size() > 0), 1);
               if (b_q[i].size() > 0) chk($sformatf("bresp_m%0d", i), 64'(s_bresp[i*2 +: 2]), 64'(b_q[i].pop_front()));
            end
            if (s_rvalid[i] && s_rready[i]) begin
               r_ord.push_back(i);
               chk($sformatf("r_expected_m%0d", i), 64'(r_q[i].size() > 0), 1);
               if (r_q[i].size() > 0) chk($sformatf("rresp_rdata_m%0d", i), 64'({s_rresp[i*2 +: 2], s_rdata[i*DW +: DW]}), 64'(r_q[i].pop_front()));
            end
         end
      end
   end

   function automatic int pending();
      int p = 0;
      for (int i = 0; i < N; i++) p += b_q[i].size() + r_q[i].size();
      return p;
   endfunction

   task automatic do_reset(input string tag);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_busy"}, 64'(busy), 0);
      chk({tag, "_grant"}, 64'(grant), 1);
      chk({tag, "_up_handshake"}, 64'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid}), 0);
      chk({tag, "_down_handshake"}, 64'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 0);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wr(input int m, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, input int skew);
      int   cyc = 0;
      logic aw_hs, w_hs;
      b_q[m].push_back(2'b00);
      s_awaddr[m*AW +: AW] = addr;
      s_wdata[m*DW +: DW]  = data;
      s_wstrb[m*SW +: SW]  = strb;
      s_wvalid[m]  = 1'b1;
      s_awvalid[m] = (skew == 0);
      while ((s_awvalid[m] || s_wvalid[m] || skew > 0) && cyc < BOUND) begin
         @(negedge clk);
         aw_hs = s_awvalid[m] & s_awready[m];
         w_hs  = s_wvalid[m] & s_wready[m];
         @(posedge clk);
         #1 cyc++;
         if (aw_hs) s_awvalid[m] = 1'b0;
         if (w_hs) s_wvalid[m] = 1'b0;
         if (skew > 0) begin
            skew--;
            if (skew == 0) s_awvalid[m] = 1'b1;
         end
      end
      chk($sformatf("wr_handshake_in_time_m%0d", m), 64'(cyc < BOUND), 1);
      s_awvalid[m] = 1'b0;
      s_wvalid[m]  = 1'b0;
   endtask

   task automatic ar(input int m, input logic [31:0] addr);
      int   cyc = 0;
      logic hs = 1'b0;
      s_araddr[m*AW +: AW] = addr;
      s_arvalid[m] = 1'b1;
      while (s_arvalid[m] && cyc < BOUND) begin
         @(negedge clk);
         hs = s_arready[m];
         @(posedge clk);
         #1 cyc++;
         if (hs) s_arvalid[m] = 1'b0;
      end
      chk($sformatf("ar_handshake_m%0d", m), 64'(hs), 1);
      s_arvalid[m] = 1'b0;
   endtask

   task automatic rd(input int m, input logic [31:0] addr, input logic [31:0] exp);
      r_q[m].push_back({2'b00, exp});
      ar(m, addr);
   endtask

   task automatic drain();
      int cyc = 0;
      while ((busy || pending() != 0) && cyc < BOUND) begin
         @(negedge clk);
         cyc++;
      end
      chk("drain_in_time", 64'(cyc < BOUND), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nw, nb, nr, k;
      do_reset("por");
      phase = 1;
      wr(0, 32'h10, 32'h00AB_CDEF, 4'hF, 0);
      drain();
      chk("grant_after_m0_write", 64'(grant), 0);
      rd(0, 32'h10, 32'h00AB_CDEF);
      drain();
      chk("grant_after_m0_read", 64'(grant), 0);
      phase = 0;
      chk("m1_outputs_quiet", 64'(m1_act), 0);

      do_reset("rst2");
      b_ord.delete();
      fork
         wr(0, 32'h10, 32'h1, 4'hF, 0);
         wr(1, 32'h14, 32'h2, 4'hF, 0);
      join
      drain();
      chk("simul_count", 64'(b_ord.size()), 2);
      chk("simul_first_m0", 64'(b_ord[0]), 0);
      chk("simul_second_m1", 64'(b_ord[1]), 1);
      rd(0, 32'h10, 32'h1);
      rd(1, 32'h14, 32'h2);
      drain();

      r_ord.delete();
      fork
         begin
            rd(0, 32'h10, 32'h1);
            rd(0, 32'h10, 32'h1);
            rd(0, 32'h10, 32'h1);
         end
         begin
            @(posedge clk);
            #1 rd(1, 32'h14, 32'h2);
         end
      join
      drain();
      chk("starve_total", 64'(r_ord.size()), 4);
      chk("starve_m1_second", 64'(r_ord[1]), 1);

      nw = n_wr;
      nb = n_bdn;
      b_ord.delete();
      wr(1, 32'h18, 32'h5A5A, 4'hF, 3);
      drain();
      chk("skew_one_write", 64'(n_wr - nw), 1);
      chk("skew_one_bresp_down", 64'(n_bdn - nb), 1);
      chk("skew_b_count", 64'(b_ord.size()), 1);
      chk("skew_b_to_m1", 64'(b_ord[0]), 1);
      rd(1, 32'h18, 32'h5A5A);
      drain();
      wr(0, 32'h18, 32'hFFFF_FFFF, 4'b0010, 0);
      drain();
      rd(0, 32'h18, 32'h0000_FF5A);
      drain();

      hold_r = 1'b1;
      nr = r_ord.size();
      ar(0, 32'h10);
      @(negedge clk);
      chk("mid_busy", 64'(busy), 1);
      do_reset("mid");
      hold_r = 1'b0;
      chk("mid_no_response", 64'(r_ord.size() - nr), 0);
      wr(0, 32'h1C, 32'h77, 4'hF, 0);
      drain();
      chk("post_reset_grant", 64'(grant), 0);
      rd(0, 32'h1C, 32'h77);
      drain();

`ifdef AXI_ARB_TIMEOUT_EN
      hold_r = 1'b1;
      r_q[0].push_back({2'b10, 32'h0});
      ar(0, 32'h10);
      k = 0;
      while (!s_rvalid[0] && k < 100) begin
         @(negedge clk);
         if (!s_rvalid[0]) k++;
      end
      chk("timeout_cycles", 64'(k), 16);
      drain();
      hold_r = 1'b0;
      repeat (4) @(negedge clk);
      chk("late_response_drained", 64'(sl_rp), 0);
      chk("timeout_idle", 64'(busy), 0);
      @(posedge clk);
      #1 rd(0, 32'h10, 32'h1);
      drain();
`else
      k = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed running expected done");
      $fatal(1, "watchdog expired");
   end
endmodule
